// File: rtl/echo_pipe_hub.sv
// echo_pipe_hub: multi-channel echo endpoint. Request words are staged, decoded
// by header into per-channel echo FIFOs (plain or +1 payload), or consumed as
// channel config, or dropped and counted. A round-robin arbiter feeds a single
// output register that drives the indication pipe.
module echo_pipe_hub #(
    parameter int NUM_CH = 4,
    parameter int HDR_W  = 16,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    parameter int ERR_W  = 16
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      req_enq_ENA,
    input  logic [HDR_W+DATA_W-1:0]   req_enq_v,
    output logic                      req_enq_RDY,
    output logic                      ind_enq_ENA,
    output logic [HDR_W+DATA_W-1:0]   ind_enq_v,
    input  logic                      ind_enq_RDY,
    output logic [ERR_W-1:0]          drop_count,
    output logic                      busy
);

    localparam int W  = HDR_W + DATA_W;
    localparam int MW = HDR_W - 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // input stage
    logic              stage_full;
    logic [W-1:0]      stage_word;
    logic [7:0]        s_chan;
    logic [MW-1:0]     s_method;
    logic [DATA_W-1:0] s_payload;
    logic [NUM_CH-1:0] ch_hit;
    logic              in_range, is_echo, is_cfg, is_drop;
    logic              blocked, stage_drains, accept, mode_sel;
    logic [W-1:0]      echo_word;

    // channel state
    logic [NUM_CH-1:0] mode;
    logic [PW:0]       wr_ptr [NUM_CH];
    logic [PW:0]       rd_ptr [NUM_CH];
    logic [W-1:0]      mem    [NUM_CH][DEPTH];
    logic [NUM_CH-1:0] empty, full, push, pop;

    // output side
    logic              out_full;
    logic [W-1:0]      out_word;
    logic [CW-1:0]     rr_ptr, rr_next;
    logic              found, fire, load_en;
    logic [W-1:0]      head;

    assign s_payload = stage_word[DATA_W-1:0];
    assign s_chan    = stage_word[DATA_W+7:DATA_W];
    assign s_method  = stage_word[W-1:DATA_W+8];

    // channel match, FIFO status and push selection for the staged word
    always_comb begin
        ch_hit = '0;
        empty  = '0;
        full   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_hit[c] = ({1'b0, s_chan} == 9'(c));
            empty[c]  = (wr_ptr[c] == rd_ptr[c]);
            full[c]   = (wr_ptr[c] == {~rd_ptr[c][PW], rd_ptr[c][PW-1:0]});
        end
        in_range     = |ch_hit;
        is_echo      = stage_full & in_range & (s_method == '0);
        is_cfg       = stage_full & in_range & (s_method == MW'(1));
        is_drop      = stage_full & ~is_echo & ~is_cfg;
        // a full target still accepts when it is popped in the same cycle
        blocked      = |(ch_hit & full & ~pop);
        stage_drains = stage_full & (~is_echo | ~blocked);
        push         = (is_echo & stage_drains) ? ch_hit : '0;
        mode_sel     = |(ch_hit & mode);
        echo_word    = {{MW{1'b0}}, s_chan,
                        mode_sel ? s_payload + DATA_W'(1) : s_payload};
    end

    assign req_enq_RDY = ~stage_full | stage_drains;
    assign accept      = req_enq_ENA & req_enq_RDY;

    // input stage register
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            stage_full <= 1'b0;
            stage_word <= '0;
        end else if (accept) begin
            stage_full <= 1'b1;
            stage_word <= req_enq_v;
        end else if (stage_drains) begin
            stage_full <= 1'b0;
        end
    end

    // channel modes and saturating drop counter
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            mode       <= '0;
            drop_count <= '0;
        end else begin
            if (is_cfg)
                mode <= (mode & ~ch_hit) | (ch_hit & {NUM_CH{s_payload[0]}});
            if (is_drop && drop_count != '1)
                drop_count <= drop_count + ERR_W'(1);
        end
    end

    // FIFO pointers
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + (PW+1)'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + (PW+1)'(1);
            end
        end
    end

    // FIFO storage, no reset needed since pointers gate visibility
    always_ff @(posedge CLK) begin
        for (int unsigned c = 0; c < NUM_CH; c++)
            if (push[c]) mem[c][wr_ptr[c][PW-1:0]] <= echo_word;
    end

    assign fire    = out_full & ind_enq_RDY;
    assign load_en = ~out_full | fire;

    // round-robin pick of the first non-empty FIFO starting at rr_ptr
    always_comb begin
        int unsigned idx;
        idx     = 0;
        found   = 1'b0;
        rr_next = rr_ptr;
        head    = '0;
        pop     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && !empty[idx]) begin
                found   = 1'b1;
                head    = mem[idx][rd_ptr[idx][PW-1:0]];
                rr_next = (idx + 1 == NUM_CH) ? '0 : CW'(idx + 1);
                pop[idx] = load_en;
            end
        end
    end

    // output register and round-robin pointer
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            out_full <= 1'b0;
            out_word <= '0;
            rr_ptr   <= '0;
        end else if (load_en) begin
            if (found) begin
                out_full <= 1'b1;
                out_word <= head;
                rr_ptr   <= rr_next;
            end else begin
                out_full <= 1'b0;
            end
        end
    end

    assign ind_enq_ENA = out_full;
    assign ind_enq_v   = out_word;
    assign busy        = stage_full | out_full | ~(&empty);

endmodule

// File: tb/tb_echo_pipe_hub.sv
// Directed testbench for echo_pipe_hub with hand-computed expected words.
module tb_echo_pipe_hub;

    localparam int HDR_W  = 16;
    localparam int DATA_W = 128;
    localparam int W      = HDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic [W-1:0]      v;
    logic              req_rdy;
    logic              ind_ena;
    logic [W-1:0]      ind_v;
    logic              rdy;
    logic [15:0]       drops;
    logic              busy;

    logic              ena_e;
    logic [W-1:0]      v_e;
    logic              req_rdy_e;
    logic              ind_ena_e;
    logic [W-1:0]      ind_v_e;
    logic              rdy_e;
    logic [1:0]        drops_e;
    logic              busy_e;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    echo_pipe_hub #(.NUM_CH(4), .HDR_W(HDR_W), .DATA_W(DATA_W), .DEPTH(4), .ERR_W(16)) dut (
        .CLK(clk), .nRST(rst),
        .req_enq_ENA(ena), .req_enq_v(v), .req_enq_RDY(req_rdy),
        .ind_enq_ENA(ind_ena), .ind_enq_v(ind_v), .ind_enq_RDY(rdy),
        .drop_count(drops), .busy(busy)
    );

    echo_pipe_hub #(.NUM_CH(4), .HDR_W(HDR_W), .DATA_W(DATA_W), .DEPTH(4), .ERR_W(2)) dut_e (
        .CLK(clk), .nRST(rst),
        .req_enq_ENA(ena_e), .req_enq_v(v_e), .req_enq_RDY(req_rdy_e),
        .ind_enq_ENA(ind_ena_e), .ind_enq_v(ind_v_e), .ind_enq_RDY(rdy_e),
        .drop_count(drops_e), .busy(busy_e)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] word(input logic [15:0] h, input logic [DATA_W-1:0] p);
        return {h, p};
    endfunction

    // present one request word and hold it until it is accepted on a rising edge
    task automatic send(input logic [15:0] h, input logic [DATA_W-1:0] p);
        int n;
        n = 0;
        @(negedge clk);
        ena = 1'b1;
        v   = {h, p};
        while (!req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", W'(req_rdy), W'(1));
        @(posedge clk);
        #1 ena = 1'b0;
    endtask

    // wait for an indication, compare it, then consume it with a one-cycle RDY
    task automatic recv(input string tag, input logic [W-1:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!ind_ena && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ena"}, W'(ind_ena), W'(1));
        check(tag, ind_v, exp);
        rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] ones;
        ones  = '1;
        rst   = 1'b1;
        ena   = 1'b0;
        v     = '0;
        rdy   = 1'b0;
        ena_e = 1'b0;
        v_e   = '0;
        rdy_e = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_req_rdy", W'(req_rdy), W'(1));
        check("rst_ind_ena", W'(ind_ena), W'(0));
        check("rst_ind_v",   ind_v,       '0);
        check("rst_drops",   W'(drops),   W'(0));
        check("rst_busy",    W'(busy),    W'(0));
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_rdy", W'(req_rdy), W'(1));

        // single echo, latency and hold under RDY=0
        send(16'h0002, 128'hDEAD);
        @(negedge clk);
        check("lat_t",   W'(ind_ena), W'(0));
        @(negedge clk);
        check("lat_t1",  W'(ind_ena), W'(0));
        @(negedge clk);
        check("lat_t2",  W'(ind_ena), W'(1));
        check("echo_v",  ind_v, word(16'h0002, 128'hDEAD));
        repeat (3) @(negedge clk);
        check("hold_ena", W'(ind_ena), W'(1));
        check("hold_v",   ind_v, word(16'h0002, 128'hDEAD));
        check("echo_drops", W'(drops), W'(0));
        rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;
        @(negedge clk);
        check("echo_done_ena", W'(ind_ena), W'(0));

        // mode switch on ch1: increment wraps, then back to plain
        send(16'h0101, 128'h1);
        send(16'h0001, ones);
        recv("inc_wrap", word(16'h0001, 128'h0));
        send(16'h0101, 128'h0);
        send(16'h0001, 128'h5);
        recv("plain5", word(16'h0001, 128'h5));
        repeat (3) @(negedge clk);
        check("cfg_no_ind", W'(ind_ena), W'(0));

        // fairness between ch0 and ch3
        for (int i = 0; i < 3; i++) send(16'h0000, DATA_W'(32'hA0 + i));
        for (int i = 0; i < 3; i++) send(16'h0003, DATA_W'(32'hB0 + i));
        recv("rr0", word(16'h0000, 128'hA0));
        recv("rr1", word(16'h0003, 128'hB0));
        recv("rr2", word(16'h0000, 128'hA1));
        recv("rr3", word(16'h0003, 128'hB1));
        recv("rr4", word(16'h0000, 128'hA2));
        recv("rr5", word(16'h0003, 128'hB2));

        // backpressure: DEPTH+2 words to ch0 fill FIFO, output and stage
        for (int i = 0; i < 6; i++) send(16'h0000, DATA_W'(32'h10 + i));
        repeat (2) @(negedge clk);
        check("bp_req_rdy", W'(req_rdy), W'(0));
        check("bp_busy",    W'(busy),    W'(1));
        check("bp_head",    ind_v, word(16'h0000, 128'h10));
        for (int i = 0; i < 6; i++) recv("bp_out", word(16'h0000, DATA_W'(32'h10 + i)));
        repeat (3) @(negedge clk);
        check("bp_idle_busy", W'(busy), W'(0));
        check("bp_idle_rdy",  W'(req_rdy), W'(1));

        // drops: channel out of range, method out of range
        send(16'h0004, 128'h1);
        send(16'h0500, 128'h2);
        repeat (3) @(negedge clk);
        check("drop_count", W'(drops),   W'(2));
        check("drop_noind", W'(ind_ena), W'(0));
        check("drop_busy",  W'(busy),    W'(0));

        // drop counter saturation on the narrow-counter instance
        @(negedge clk);
        ena_e = 1'b1;
        v_e   = word(16'h0009, 128'h0);
        @(negedge clk);
        @(negedge clk);
        check("sat_partial", W'(drops_e), W'(1));
        repeat (3) @(negedge clk);
        ena_e = 1'b0;
        repeat (2) @(negedge clk);
        check("sat_count", W'(drops_e), W'(3));

        // async reset mid-stream with words queued, ch1 left in increment mode
        send(16'h0101, 128'h1);
        for (int i = 0; i < 3; i++) send(16'h0000, DATA_W'(32'h30 + i));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_ena",     W'(ind_ena), W'(0));
        check("arst_v",       ind_v,       '0);
        check("arst_busy",    W'(busy),    W'(0));
        check("arst_req_rdy", W'(req_rdy), W'(1));
        check("arst_drops",   W'(drops),   W'(0));
        #3 rst = 1'b0;
        rdy = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_no_stale", W'(ind_ena), W'(0));
        check("arst_idle",     W'(busy),    W'(0));
        rdy = 1'b0;
        send(16'h0001, 128'h7);
        recv("arst_mode_clr", word(16'h0001, 128'h7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/echo_pipe_hub.md
Name: echo_pipe_hub

Overview:
Parametrised multi-channel echo endpoint that terminates one request pipe and drives one indication pipe.
- It replaces the fixed single-channel request/indication shim pair and echo core with one block.
- It decodes a header on each request word and routes the word to one of NUM_CH per-channel echo FIFOs.
- Each channel can be set to plain or incrementing echo mode.
- Responses are returned on the indication pipe under round-robin arbitration.

Parameters:
NUM_CH, 4, number of echo channels (1..256)
HDR_W, 16, header width; bits [7:0] = channel id, bits [HDR_W-1:8] = method id
DATA_W, 128, payload width
DEPTH, 4, entries per channel FIFO (power of 2, >=2)
ERR_W, 16, width of the drop counter

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  reset, asynchronous, active-high (asserted = 1)
req_enq_ENA  in  1  request word valid
req_enq_v  in  HDR_W+DATA_W  request word {header, payload}
req_enq_RDY  out  1  request word accepted when ENA&RDY
ind_enq_ENA  out  1  indication word valid
ind_enq_v  out  HDR_W+DATA_W  indication word {header, payload}
ind_enq_RDY  in  1  downstream can accept
drop_count  out  ERR_W  count of discarded request words, saturating
busy  out  1  any FIFO, stage or output register occupied

Behaviour:
- Reset (async assert, sync-free): all FIFOs empty, input stage empty, output register empty.
  - Outputs during and after reset: req_enq_RDY=1, ind_enq_ENA=0, ind_enq_v=0, drop_count=0, busy=0.
  - All channel modes=0. Round-robin pointer=0.
  - Reset mid-transfer discards all in-flight words; no partial indication is emitted.
- Input stage: one register.
  - req_enq_RDY = !stage_full | stage_drains.
  - The stage drains in the same cycle if its target FIFO is not full, or if the word is config/invalid.
  - Head-of-line blocking is intended: a full channel stalls all channels.
- Decode of a staged word:
  - method 0 and chan < NUM_CH: echo. Push {header, payload'} to FIFO[chan].
    - mode 0: payload' = payload.
    - mode 1: payload' = payload + 1 mod 2^DATA_W.
  - method 1 and chan < NUM_CH: config. mode[chan] <= payload[0]. No indication. Takes effect for words staged on later cycles.
  - anything else (chan >= NUM_CH or method > 1): drop. drop_count += 1, saturating at 2^ERR_W-1.
- Response header: same channel id, method 0.
- Channel FIFOs:
  - Circular buffers of DEPTH entries with log2(DEPTH)+1-bit pointers. Full when pointers differ only in the MSB.
  - Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.
  - Simultaneous push and pop on an empty FIFO is not permitted: the pop sees empty that cycle.
- Output register and arbitration:
  - The register loads when empty, or when it fires this cycle (ind_enq_ENA & ind_enq_RDY).
  - Source is the first non-empty FIFO searching from rr_ptr upward, wrapping mod NUM_CH.
  - After a load from channel k, rr_ptr <= (k+1) mod NUM_CH.
  - ind_enq_ENA/ind_enq_v stay stable while ENA=1 and RDY=0.
  - Full throughput: one word per cycle when downstream is always ready.
- Latency: a word accepted on edge t is staged after t, written to its FIFO at t+1, and loaded to the output at t+2. ind_enq_ENA is high after edge t+2, i.e. 2 cycles minimum.
- busy = stage_full | output_full | any FIFO non-empty.

Test Plan:
- Reset then single echo: send hdr=0x0002, payload=0xDEAD on ch2 -> 2 cycles later ind_enq_v={0x0002,0xDEAD}, ENA held 1 until RDY; drop_count=0.
- Mode switch: config ch1 with payload 1, then echo ch1 payload 0xFF…FF -> response payload 0 (wrap); config ch1 payload 0, echo 5 -> response 5.
- Fairness: hold ind_enq_RDY=0, preload ch0 x3 and ch3 x3, release RDY -> output order ch0,ch3,ch0,ch3,ch0,ch3.
- Backpressure/full: RDY=0, send DEPTH+2 echoes to ch0 -> DEPTH in FIFO, 1 in output reg, 1 in stage, req_enq_RDY=0; release -> all DEPTH+2 delivered in order, none lost.
- Drops: send chan=NUM_CH then method=5 on ch0 -> no indications, drop_count=2; with ERR_W=2 send 5 drops -> drop_count saturates at 3.
- Async reset mid-stream: assert nRST=1 between clock edges with 3 words queued -> ind_enq_ENA=0 immediately, busy=0, no stale word after release.
